// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: opcodes, ALU/mux select codes and FSM state encodings
package multicycle_control_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [2:0] ALOP_ADD   = 3'b000;
  localparam logic [2:0] ALOP_SUB   = 3'b001;
  localparam logic [2:0] ALOP_FUNCT = 3'b111;
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ      = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd12,
    S_HALT     = 4'd13
  } state_t;
endpackage

// File: rtl/multicycle_control_retire_counter.sv
// retire_counter: wrapping up-counter with enable and synchronous reset
module retire_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q, count_d;
  // next count wraps naturally at 2^W
  always_comb count_d = en_i ? count_q + W'(1) : count_q;
  // count register
  always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
  assign count_o = count_q;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle CPU controller FSM driving datapath muxes and enables
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int RETIRE_W     = 16,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pcwrite,
  output logic                pcwritecond,
  output logic                iord,
  output logic                memread,
  output logic                memwrite,
  output logic                irwrite,
  output logic                memreg,
  output logic                regdst,
  output logic                regwrite,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [2:0]          alop,
  output logic [1:0]          pcsrc,
  output logic                instr_done,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);
  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   unused;
  // zero only gates pcwritecond inside the datapath
  assign unused = zero;
  // state and sticky illegal flag registers
  always_ff @(posedge clk) begin
    state_q   <= rst ? S_FETCH : state_d;
    illegal_q <= rst ? 1'b0 : illegal_d;
  end
  // next-state and output decode; pcwrite/irwrite/instr_done are the only mem_ready-qualified terms
  always_comb begin
    state_d     = S_FETCH;
    illegal_d   = illegal_q;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memreg      = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_RT;
    alop        = ALOP_ADD;
    pcsrc       = PCSRC_ALU;
    instr_done  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        pcwrite = mem_ready;
        irwrite = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMM_SH;
        case (op)
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memreg     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPE_EX: begin
        alusrca = 1'b1;
        alop    = ALOP_FUNCT;
        state_d = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alusrca     = 1'b1;
        alop        = ALOP_SUB;
        pcsrc       = PCSRC_ALUOUT;
        pcwritecond = 1'b1;
        instr_done  = 1'b1;
      end
      S_ADDI_EX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pcsrc      = PCSRC_JUMP;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        illegal_d = 1'b1;
        state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end
  assign illegal = illegal_q;
  retire_counter #(.W(RETIRE_W)) u_retire (
    .clk     (clk),
    .rst     (rst),
    .en_i    (instr_done),
    .count_o (retired)
  );
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-level model compare plus directed literal checks
module tb_multicycle_control;
  localparam logic [5:0] T_RT = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010, T_BAD = 6'b111111;
  localparam int CL_RT = 0, CL_LW = 1, CL_SW = 2, CL_BEQ = 3, CL_ADDI = 4, CL_J = 5, CL_ILL = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic zero = 1'b0;
  logic mem_ready = 1'b1;
  logic [1:0] pw, pwc, iord, mrd, mwr, irw, mreg, rdst, rwr, asa, done, ill;
  logic [1:0] asb [2];
  logic [2:0] alo [2];
  logic [1:0] psrc [2];
  logic [3:0] ret0;
  logic [15:0] ret1;
  int n_chk = 0, n_fail = 0;
  int s_pwc, s_mw, s_beqsig;
  bit valid = 1'b0;
  int m_step [2], m_cls [2], m_ret [2];
  bit m_halt [2], m_ill [2];
  always #5 clk = ~clk;
  multicycle_control #(.RETIRE_W(4), .ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(pw[0]), .pcwritecond(pwc[0]), .iord(iord[0]), .memread(mrd[0]), .memwrite(mwr[0]),
    .irwrite(irw[0]), .memreg(mreg[0]), .regdst(rdst[0]), .regwrite(rwr[0]), .alusrca(asa[0]),
    .alusrcb(asb[0]), .alop(alo[0]), .pcsrc(psrc[0]), .instr_done(done[0]), .illegal(ill[0]),
    .retired(ret0));
  multicycle_control #(.RETIRE_W(16), .ILLEGAL_HALT(1'b1)) dut_h (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(pw[1]), .pcwritecond(pwc[1]), .iord(iord[1]), .memread(mrd[1]), .memwrite(mwr[1]),
    .irwrite(irw[1]), .memreg(mreg[1]), .regdst(rdst[1]), .regwrite(rwr[1]), .alusrca(asa[1]),
    .alusrcb(asb[1]), .alop(alo[1]), .pcsrc(psrc[1]), .instr_done(done[1]), .illegal(ill[1]),
    .retired(ret1));
  task automatic check(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [17:0] got(int k);
    return {pw[k], pwc[k], iord[k], mrd[k], mwr[k], irw[k], mreg[k], rdst[k], rwr[k], asa[k],
            asb[k], alo[k], psrc[k], done[k]};
  endfunction
  function automatic int cls_of(logic [5:0] o);
    case (o)
      T_RT: return CL_RT;
      T_LW: return CL_LW;
      T_SW: return CL_SW;
      T_BEQ: return CL_BEQ;
      T_ADDI: return CL_ADDI;
      T_J: return CL_J;
      default: return CL_ILL;
    endcase
  endfunction
  function automatic int len_of(int c);
    case (c)
      CL_LW: return 5;
      CL_RT, CL_SW, CL_ADDI: return 4;
      default: return 3;
    endcase
  endfunction
  function automatic logic [17:0] expv(int c, int s, bit h, logic m);
    logic p_w, p_wc, i_o, r_d, w_r, i_r, m_g, d_s, r_w, a_a, d_n;
    logic [1:0] b_b, p_s;
    logic [2:0] a_l;
    {p_w, p_wc, i_o, r_d, w_r, i_r, m_g, d_s, r_w, a_a, d_n} = '0;
    b_b = 2'b00; p_s = 2'b00; a_l = 3'b000;
    if (!h) begin
      if (s == 0) begin r_d = 1; b_b = 2'b01; p_w = m; i_r = m; end
      else if (s == 1) b_b = 2'b11;
      else case (c)
        CL_RT: if (s == 2) begin a_a = 1; a_l = 3'b111; end else begin d_s = 1; r_w = 1; d_n = 1; end
        CL_LW: if (s == 2) begin a_a = 1; b_b = 2'b10; end
               else if (s == 3) begin i_o = 1; r_d = 1; end
               else begin m_g = 1; r_w = 1; d_n = 1; end
        CL_SW: if (s == 2) begin a_a = 1; b_b = 2'b10; end else begin i_o = 1; w_r = 1; d_n = m; end
        CL_BEQ: begin a_a = 1; a_l = 3'b001; p_s = 2'b01; p_wc = 1; d_n = 1; end
        CL_ADDI: if (s == 2) begin a_a = 1; b_b = 2'b10; end else begin r_w = 1; d_n = 1; end
        CL_J: begin p_s = 2'b10; p_w = 1; d_n = 1; end
        default: ;
      endcase
    end
    return {p_w, p_wc, i_o, r_d, w_r, i_r, m_g, d_s, r_w, a_a, b_b, a_l, p_s, d_n};
  endfunction
  function automatic int cur_cls(int k);
    return (m_step[k] == 1) ? cls_of(op) : m_cls[k];
  endfunction
  function automatic bit stall(int k);
    return (m_step[k] == 0 || (m_step[k] == 3 && (m_cls[k] == CL_LW || m_cls[k] == CL_SW))) && !mem_ready;
  endfunction
  function automatic bit exp_done(int k);
    logic [17:0] v;
    v = expv(cur_cls(k), m_step[k], 1'b0, mem_ready);
    return v[0];
  endfunction
  function automatic bit last(int k);
    return !stall(k) && (m_step[k] + 1 == len_of(cur_cls(k)));
  endfunction
  // instruction-step model: advances one cycle per edge, holding on memory waits
  always @(posedge clk) begin
    if (rst) begin
      valid <= 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_step[k] <= 0; m_cls[k] <= CL_RT; m_ret[k] <= 0; m_ill[k] <= 1'b0; m_halt[k] <= 1'b0;
      end
    end else if (valid) begin
      for (int k = 0; k < 2; k++) if (!m_halt[k]) begin
        m_cls[k] <= cur_cls(k);
        m_ret[k] <= m_ret[k] + int'(exp_done(k));
        if (!stall(k)) m_step[k] <= last(k) ? 0 : m_step[k] + 1;
        if (last(k) && cur_cls(k) == CL_ILL) begin
          m_ill[k] <= 1'b1;
          if (k == 1) m_halt[k] <= 1'b1;
        end
      end
    end
  end
  // every-cycle compare against the model
  always @(negedge clk) if (valid) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("model_outs[%0d]", k), 32'(got(k)), 32'(expv(m_cls[k], m_step[k], m_halt[k], mem_ready)));
      check($sformatf("model_illegal[%0d]", k), 32'(ill[k]), 32'(m_ill[k]));
    end
    check("model_retired[0]", 32'(ret0), 32'(m_ret[0] % 16));
    check("model_retired[1]", 32'(ret1), 32'(m_ret[1] % 65536));
  end
  task automatic drive(logic r, logic [5:0] o, logic m);
    @(posedge clk);
    #1;
    rst = r; op = o; mem_ready = m; zero = 1'($urandom % 2);
    @(negedge clk);
    s_pwc += int'(pwc[0]);
    s_mw += int'(mwr[0]);
    s_beqsig += int'(alo[0] == 3'b001 && psrc[0] == 2'b01);
  endtask
  task automatic instr(logic [5:0] o, int n);
    for (int i = 0; i < n; i++) drive(1'b0, o, 1'b1);
  endtask
  initial begin
    drive(1'b1, T_RT, 1'b1);
    drive(1'b1, T_RT, 1'b1);
    check("rst_memread", mrd[0], 1);
    check("rst_pcwrite", pw[0], 1);
    check("rst_irwrite", irw[0], 1);
    check("rst_regwrite", rwr[0], 0);
    check("rst_retired", ret0, 0);
    check("rst_illegal", ill[0], 0);
    drive(1'b0, T_RT, 1'b1);
    drive(1'b0, T_RT, 1'b1);
    check("rt_c2_regwrite", rwr[0], 0);
    drive(1'b0, T_RT, 1'b1);
    check("rt_c3_alop", alo[0], 3'b111);
    check("rt_c3_done", done[0], 0);
    drive(1'b0, T_RT, 1'b1);
    check("rt_c4_done", done[0], 1);
    check("rt_c4_regwrite", rwr[0], 1);
    check("rt_c4_regdst", rdst[0], 1);
    drive(1'b0, T_LW, 1'b1);
    check("rt_retired", ret0, 1);
    drive(1'b0, T_LW, 1'b1);
    drive(1'b0, T_LW, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, T_LW, i == 3);
      check($sformatf("lw_wait%0d_iord_memread", i), {iord[0], mrd[0]}, 2'b11);
    end
    drive(1'b0, T_LW, 1'b1);
    check("lw_c8_regwrite", rwr[0], 1);
    check("lw_c8_memreg", mreg[0], 1);
    s_pwc = 0; s_mw = 0; s_beqsig = 0;
    instr(T_SW, 4);
    instr(T_BEQ, 3);
    check("swbeq_memwrite_cycles", s_mw, 1);
    check("swbeq_pcwritecond_cycles", s_pwc, 1);
    check("swbeq_sub_aluout_cycles", s_beqsig, 1);
    drive(1'b0, T_ADDI, 1'b1);
    check("swbeq_retired", ret0, 4);
    instr(T_ADDI, 3);
    instr(T_J, 3);
    instr(T_BAD, 3);
    drive(1'b0, T_RT, 1'b1);
    check("ill_flag", ill[0], 1);
    check("ill_retired", ret0, 6);
    check("ill_back_in_fetch", mrd[0], 1);
    check("halt_flag", ill[1], 1);
    check("halt_outputs", 32'(got(1)), 0);
    instr(T_RT, 3);
    check("halt_still_zero", 32'(got(1)), 0);
    drive(1'b1, T_RT, 1'b1);
    drive(1'b1, T_RT, 1'b1);
    check("halt_cleared_by_rst", {ill[1], mrd[1]}, 2'b01);
    instr(T_SW, 3);
    drive(1'b1, T_SW, 1'b0);
    check("memwr_before_rst", mwr[0], 1);
    drive(1'b0, T_RT, 1'b1);
    check("memwr_rst_memwrite", mwr[0], 0);
    check("memwr_rst_fetch", mrd[0], 1);
    check("memwr_rst_retired", ret0, 0);
    drive(1'b1, T_J, 1'b1);
    for (int i = 0; i < 15; i++) instr(T_J, 3);
    drive(1'b0, T_J, 1'b1);
    check("wrap_at_max", ret0, 15);
    instr(T_J, 2);
    drive(1'b0, T_J, 1'b1);
    check("wrap_to_zero", ret0, 0);
    check("wide_no_wrap", ret1, 16);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
